pipeline_debug_controller: RTL and testbench
============================================

# pipeline_debug_controller

Sequencing controller for the five-stage MIPS pipeline. It receives byte commands from a serial receiver, loads program words into instruction memory, and gates the pipeline's halt input for continuous-run and single-step execution. After each execution command it reports PC (and optionally the cycle count) back through a serial transmitter. It sits between the UART and the pipeline top and is the only driver of the pipeline's instruction-memory write port and halt.

## Interface
Parameters:
- `MAX_WORDS`, default 256. Maximum words per load; the count byte is clamped to this value.

Ports:
- `i_clk`, in, 1. Single clock.
- `i_reset`, in, 1. Synchronous, active-high reset.
- `i_rx_data`, in, 8. Received byte.
- `i_rx_valid`, in, 1. One-cycle strobe marking `i_rx_data` valid.
- `o_tx_data`, out, 8. Byte to transmit. Held stable from `o_tx_start` until busy drops.
- `o_tx_start`, out, 1. One-cycle transmit request.
- `i_tx_busy`, in, 1. Transmitter busy. Asserted the cycle after `o_tx_start`.
- `o_write_instruction_mem`, out, 1. One-cycle instruction-memory write enable.
- `o_instruction_mem_addr`, out, 32. Byte address of the write (word index × 4).
- `o_instruction_mem_data`, out, 32. Instruction word to write.
- `o_halt`, out, 1. 1 freezes the pipeline; 0 lets it advance.
- `i_pc`, in, 32. Current fetch PC from the pipeline.
- `i_program_end`, in, 1. HALT instruction has retired.
- `o_state`, out, 3. FSM state encoding, for debug only.

## Operation
- States: IDLE, LOAD_CNT, LOAD_BYTE, LOAD_WR, RUN, STEP, SEND, SEND_WAIT.
- Commands are accepted only in IDLE:
  - 0x4C 'L' → LOAD_CNT.
  - 0x52 'R' → RUN.
  - 0x53 'S' → STEP.
  - 0x44 'D' → SEND (dump only, no execution).
  - Any other byte is ignored.
- Bytes arriving in any state other than IDLE, LOAD_CNT or LOAD_BYTE are dropped.
- Load sequence:
  - LOAD_CNT: the next byte N sets the word count, clamped to `MAX_WORDS`. The word index and cycle counter clear.
  - N=0: go straight to SEND with ack only.
  - LOAD_BYTE: collect 4 bytes per word, big-endian (first byte goes to bits 31:24).
  - After the 4th byte, enter LOAD_WR: `o_write_instruction_mem`=1 for one cycle with addr = index×4, then the index increments.
  - If index==N, go to SEND (ack); otherwise return to LOAD_BYTE.
- RUN:
  - `o_halt`=0 every cycle until `i_program_end` is sampled 1.
  - `o_halt`=1 the cycle after that sample, then go to SEND (dump).
- STEP: `o_halt`=0 for exactly one cycle, then SEND (dump).
- Dump content:
  - 4 bytes of `i_pc`, big-endian, latched on entry to SEND.
  - With the macro defined, 4 more bytes of the cycle count, big-endian.
- Ack content: the single byte 0x4B 'K'.
- TX handshake:
  - SEND asserts `o_tx_start` when `i_tx_busy`=0.
  - SEND_WAIT ignores busy for one guard cycle, then waits for `i_tx_busy`=0.
  - Next byte follows, or the FSM returns to IDLE after the last byte.
- Cycle counter: 32-bit, increments on every cycle with `o_halt`=0 and wraps at 2^32.

## Timing
- Reset values:
  - `o_halt`=1.
  - State IDLE (`o_state`=0).
  - `o_write_instruction_mem`, `o_tx_start`=0.
  - Addr, data, `o_tx_data`=0.
  - Word index and cycle counter =0.
- Write pulse appears the cycle after the `i_rx_valid` cycle carrying the 4th byte of a word.
- `o_halt` drops the cycle after the 'R' or 'S' byte is sampled.
- If `i_program_end`=1 when 'R' is accepted: zero run cycles, immediate dump.
- 'S' while `i_program_end`=1 still produces one unhalted cycle; the pipeline's own HALT handling governs the effect.
- `i_rx_valid` coinciding with a write pulse (LOAD_WR) is dropped. Senders must space bytes at least 2 cycles apart, which any UART guarantees.
- Reset mid-operation:
  - Abort the partial load with no further write.
  - Drop any `o_tx_start`.
  - `o_halt`=1 next cycle.
  - Instruction memory contents are unaffected.

## Configuration
- `DEBUG_CYCLE_COUNT_EN` defined:
  - Cycle counter is built.
  - Dump is 8 bytes: PC followed by count.
- Not defined:
  - No counter logic.
  - Dump is 4 bytes (PC only).
  - The ack stays 1 byte either way.

## Test plan
- Reset → `o_halt`=1 and `o_state`=IDLE; drive bytes 0x00, 0x44 'D' with PC=0x0000_0010 → TX bytes 00 00 00 10, plus 4 zero count bytes when the macro is on.
- 'L', 0x02, then 8C 01 00 04 00 00 00 00 → write pulses addr 0x0 data 0x8C010004 and addr 0x4 data 0x00000000, then TX 0x4B.
- 'L', 0x00 → no write pulse; TX 0x4B only.
- 'S' with PC=0x8 → `o_halt` low for exactly 1 cycle; dump PC 00 00 00 08 and count 00 00 00 01.
- 'R', `i_program_end` raised after 20 cycles → `o_halt` low for 20 cycles, then 1; count 00 00 00 14.
- Reset asserted after the 2nd data byte of a load → no write pulse, IDLE; a later 'D' is served normally.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// ----------------------------------------------------------------------------
// pipeline_debug_controller
//   Byte-command sequencer between a UART and the five-stage MIPS pipeline.
//   It loads program words into instruction memory, runs or single-steps the
//   pipeline through o_halt, and reports the PC (and optionally the cycle
//   count) back to the UART transmitter.
//
//   Commands accepted in IDLE: 'L' load, 'R' run, 'S' step, 'D' dump.
//
//   Optional feature macro: DEBUG_CYCLE_COUNT_EN
//     defined   -> 32-bit unhalted-cycle counter built, dump = PC + count
//     undefined -> no counter, dump = PC only
//
// Ports
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_rx_data/i_rx_valid           received byte + one-cycle strobe
//   o_tx_data/o_tx_start/i_tx_busy transmit byte, start pulse, busy
//   o_write_instruction_mem        one-cycle imem write enable
//   o_instruction_mem_addr/_data   imem byte address / instruction word
//   o_halt                         1 freezes the pipeline
//   i_pc, i_program_end            pipeline fetch PC, HALT retired
//   o_state                        FSM state (debug)
// ----------------------------------------------------------------------------
module pipeline_debug_controller #(
    parameter int MAX_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_start,
    input  logic        i_tx_busy,
    output logic        o_write_instruction_mem,
    output logic [31:0] o_instruction_mem_addr,
    output logic [31:0] o_instruction_mem_data,
    output logic        o_halt,
    input  logic [31:0] i_pc,
    input  logic        i_program_end,
    output logic [2:0]  o_state
);
    localparam int IDX_W = $clog2(MAX_WORDS + 1);
`ifdef DEBUG_CYCLE_COUNT_EN
    localparam logic [2:0] DUMP_LAST = 3'd7;
`else
    localparam logic [2:0] DUMP_LAST = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_CNT  = 3'd1,
        LOAD_BYTE = 3'd2,
        LOAD_WR   = 3'd3,
        RUN       = 3'd4,
        STEP      = 3'd5,
        SEND      = 3'd6,
        SEND_WAIT = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic               halt_q, halt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [1:0]         bcnt_q, bcnt_d;
    logic [23:0]        wbuf_q, wbuf_d;
    logic [31:0]        pc_q, pc_d;
    logic [2:0]         byte_q, byte_d;
    logic               ack_q, ack_d;
    logic               guard_q, guard_d;
`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0]        cnt_q, cnt_d;
`endif

    // Byte currently due on the transmitter, big-endian within each word.
    logic [31:0] sel_word;
    logic [7:0]  next_byte;
    always_comb begin
        sel_word = pc_q;
`ifdef DEBUG_CYCLE_COUNT_EN
        if (byte_q[2]) sel_word = cnt_q;
`endif
        case (byte_q[1:0])
            2'd0:    next_byte = sel_word[31:24];
            2'd1:    next_byte = sel_word[23:16];
            2'd2:    next_byte = sel_word[15:8];
            default: next_byte = sel_word[7:0];
        endcase
        if (ack_q) next_byte = 8'h4B;
    end

    always_comb begin
        state_d    = state_q;
        halt_d     = 1'b1;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        n_d        = n_q;
        idx_d      = idx_q;
        bcnt_d     = bcnt_q;
        wbuf_d     = wbuf_q;
        pc_d       = pc_q;
        byte_d     = byte_q;
        ack_d      = ack_q;
        guard_d    = guard_q;
`ifdef DEBUG_CYCLE_COUNT_EN
        cnt_d      = halt_q ? cnt_q : cnt_q + 32'd1;
`endif
        case (state_q)
            IDLE: if (i_rx_valid) begin
                case (i_rx_data)
                    8'h4C: state_d = LOAD_CNT;
                    8'h52: begin
                        // Program already finished: dump without running.
                        if (i_program_end) begin
                            state_d = SEND; pc_d = i_pc; ack_d = 1'b0; byte_d = '0;
                        end else begin
                            state_d = RUN; halt_d = 1'b0;
                        end
                    end
                    8'h53: begin state_d = STEP; halt_d = 1'b0; end
                    8'h44: begin
                        state_d = SEND; pc_d = i_pc; ack_d = 1'b0; byte_d = '0;
                    end
                    default: ;
                endcase
            end
            LOAD_CNT: if (i_rx_valid) begin
                n_d    = (int'(i_rx_data) > MAX_WORDS) ? IDX_W'(MAX_WORDS)
                                                       : IDX_W'(i_rx_data);
                idx_d  = '0;
                bcnt_d = '0;
`ifdef DEBUG_CYCLE_COUNT_EN
                cnt_d  = '0;
`endif
                if (i_rx_data == 8'h00) begin
                    state_d = SEND; ack_d = 1'b1; byte_d = '0;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            LOAD_BYTE: if (i_rx_valid) begin
                if (bcnt_q == 2'd3) begin
                    we_d    = 1'b1;
                    addr_d  = 32'(idx_q) << 2;
                    wdata_d = {wbuf_q, i_rx_data};
                    bcnt_d  = '0;
                    state_d = LOAD_WR;
                end else begin
                    wbuf_d  = {wbuf_q[15:0], i_rx_data};
                    bcnt_d  = bcnt_q + 2'd1;
                end
            end
            LOAD_WR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q + 1'b1 == n_q) begin
                    state_d = SEND; ack_d = 1'b1; byte_d = '0;
                end else begin
                    state_d = LOAD_BYTE;
                end
            end
            RUN: begin
                if (i_program_end) begin
                    state_d = SEND; pc_d = i_pc; ack_d = 1'b0; byte_d = '0;
                end else begin
                    halt_d = 1'b0;
                end
            end
            STEP: begin
                state_d = SEND; pc_d = i_pc; ack_d = 1'b0; byte_d = '0;
            end
            SEND: if (!i_tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = next_byte;
                guard_d    = 1'b1;
                state_d    = SEND_WAIT;
            end
            SEND_WAIT: begin
                // Busy rises one cycle after start, so skip the first cycle.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!i_tx_busy) begin
                    if (ack_q || byte_q == DUMP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            halt_q     <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            n_q        <= '0;
            idx_q      <= '0;
            bcnt_q     <= '0;
            wbuf_q     <= '0;
            pc_q       <= '0;
            byte_q     <= '0;
            ack_q      <= 1'b0;
            guard_q    <= 1'b0;
`ifdef DEBUG_CYCLE_COUNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            halt_q     <= halt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            bcnt_q     <= bcnt_d;
            wbuf_q     <= wbuf_d;
            pc_q       <= pc_d;
            byte_q     <= byte_d;
            ack_q      <= ack_d;
            guard_q    <= guard_d;
`ifdef DEBUG_CYCLE_COUNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign o_state                 = state_q;
    assign o_halt                  = halt_q;
    assign o_write_instruction_mem = we_q;
    assign o_instruction_mem_addr  = addr_q;
    assign o_instruction_mem_data  = wdata_q;
    assign o_tx_start              = tx_start_q;
    assign o_tx_data               = tx_data_q;
endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Scoreboard bench for pipeline_debug_controller: stimulus pushes expected
// TX bytes and imem writes into queues, a monitor pops and compares them.
module tb_pipeline_debug_controller;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_busy = 1'b0;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr;
    logic [31:0] o_instruction_mem_data;
    logic        o_halt;
    logic [31:0] i_pc = 32'h0;
    logic        i_program_end = 1'b0;
    logic [2:0]  o_state;

    always #5 i_clk = ~i_clk;

    pipeline_debug_controller #(.MAX_WORDS(256)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .o_write_instruction_mem(o_write_instruction_mem),
        .o_instruction_mem_addr(o_instruction_mem_addr),
        .o_instruction_mem_data(o_instruction_mem_data),
        .o_halt(o_halt), .i_pc(i_pc), .i_program_end(i_program_end),
        .o_state(o_state)
    );

    int n_checks = 0;
    int n_fail = 0;
    int halt_low = 0;
    logic [7:0]  exp_tx[$];
    logic [63:0] exp_wr[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART transmitter model: busy rises the cycle after start, lasts 5 cycles.
    initial forever begin
        @(negedge i_clk);
        if (o_tx_start) begin
            @(posedge i_clk); #1 i_tx_busy = 1'b1;
            repeat (5) @(posedge i_clk);
            #1 i_tx_busy = 1'b0;
        end
    end

    // Monitor
    initial forever begin
        @(negedge i_clk);
        if (!o_halt) halt_low++;
        if (o_tx_start) begin
            if (exp_tx.size() == 0) check("unexpected tx byte", {56'h0, o_tx_data}, 64'hx_dead);
            else check("tx byte", {56'h0, o_tx_data}, {56'h0, exp_tx.pop_front()});
        end
        if (o_write_instruction_mem) begin
            if (exp_wr.size() == 0) begin
                check("unexpected imem write", {o_instruction_mem_addr, o_instruction_mem_data}, 64'hx_dead);
            end else begin
                logic [63:0] e;
                e = exp_wr.pop_front();
                check("imem addr", {32'h0, o_instruction_mem_addr}, {32'h0, e[63:32]});
                check("imem data", {32'h0, o_instruction_mem_data}, {32'h0, e[31:0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk); #1 i_rx_data = b; i_rx_valid = 1'b1;
        @(posedge i_clk); #1 i_rx_valid = 1'b0;
        repeat (2) @(posedge i_clk);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_tx.push_back(w[31:24]); exp_tx.push_back(w[23:16]);
        exp_tx.push_back(w[15:8]);  exp_tx.push_back(w[7:0]);
    endtask

    task automatic push_dump(input logic [31:0] pc, input logic [31:0] cnt);
        push_word(pc);
`ifdef DEBUG_CYCLE_COUNT_EN
        push_word(cnt);
`else
        if (cnt == 32'hFFFF_FFFF) push_word(pc); // never used with this value
`endif
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge i_clk);
            if (exp_tx.size() == 0 && exp_wr.size() == 0 && o_state == 3'd0) done = 1'b1;
        end
        check(name, {63'h0, done}, 64'h1);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset halt", {63'h0, o_halt}, 64'h1);
        check("reset state", {61'h0, o_state}, 64'h0);
        check("reset tx_start", {63'h0, o_tx_start}, 64'h0);
        check("reset we", {63'h0, o_write_instruction_mem}, 64'h0);
        check("reset addr", {32'h0, o_instruction_mem_addr}, 64'h0);
        check("reset data", {32'h0, o_instruction_mem_data}, 64'h0);
        check("reset tx_data", {56'h0, o_tx_data}, 64'h0);
        i_reset = 1'b0;

        // Ignored byte, then dump
        i_pc = 32'h10;
        base = halt_low;
        send_byte(8'h00);
        push_dump(32'h10, 32'h0);
        send_byte(8'h44);
        wait_idle("dump after reset done");
        check("dump halt-low cycles", 64'(halt_low - base), 64'd0);

        // Two-word load
        exp_wr.push_back({32'h0, 32'h8C01_0004});
        exp_wr.push_back({32'h4, 32'h0000_0000});
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h02);
        send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        wait_idle("load 2 words done");

        // Zero-length load: ack only
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h00);
        wait_idle("load 0 done");

        // Single step
        i_pc = 32'h8;
        base = halt_low;
        push_dump(32'h8, 32'h1);
        send_byte(8'h53);
        wait_idle("step done");
        check("step halt-low cycles", 64'(halt_low - base), 64'd1);

        // Clear counter, then run for 20 cycles
        exp_tx.push_back(8'h4B);
        send_byte(8'h4C); send_byte(8'h00);
        wait_idle("clear load done");
        i_pc = 32'h24;
        base = halt_low;
        push_dump(32'h24, 32'h14);
        @(posedge i_clk); #1 i_rx_data = 8'h52; i_rx_valid = 1'b1;
        @(posedge i_clk); #1 i_rx_valid = 1'b0;
        repeat (19) @(posedge i_clk);
        #1 i_program_end = 1'b1;
        @(posedge i_clk); #1 i_program_end = 1'b0;
        #2 check("halt back high after run", {63'h0, o_halt}, 64'h1);
        wait_idle("run done");
        check("run halt-low cycles", 64'(halt_low - base), 64'd20);

        // Run with program already ended: zero run cycles
        i_program_end = 1'b1;
        i_pc = 32'h30;
        base = halt_low;
        push_dump(32'h30, 32'h14);
        send_byte(8'h52);
        wait_idle("run at end done");
        check("run-at-end halt-low cycles", 64'(halt_low - base), 64'd0);
        i_program_end = 1'b0;

        // Reset in the middle of a load: no write, back to IDLE
        send_byte(8'h4C); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
        @(posedge i_clk); #1 i_reset = 1'b1;
        @(posedge i_clk); #1 i_reset = 1'b0;
        check("abort state", {61'h0, o_state}, 64'h0);
        check("abort halt", {63'h0, o_halt}, 64'h1);
        check("abort we", {63'h0, o_write_instruction_mem}, 64'h0);
        repeat (3) @(posedge i_clk);
        i_pc = 32'h40;
        push_dump(32'h40, 32'h0);
        send_byte(8'h44);
        wait_idle("dump after abort done");

        repeat (5) @(negedge i_clk);
        check("tx queue drained", 64'(exp_tx.size()), 64'd0);
        check("write queue drained", 64'(exp_wr.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
